// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall sources, branch and exception redirects into per-stage
// stall/flush vectors, with a post-exception PC hold FSM and a stall watchdog.
module pipe_ctrl #(
  parameter int unsigned              NUM_STAGES = 6,
  parameter int unsigned              NUM_REQ    = 4,
  parameter logic [3*NUM_REQ-1:0]     REQ_STAGE  = {3'd3, 3'd3, 3'd2, 3'd2},
  parameter int unsigned              BR_FLUSH   = 1,
  parameter int unsigned              HOLD_CYC   = 2,
  parameter int unsigned              WDOG_MAX   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    stallreq,
  input  logic                  flush_req,
  input  logic [31:0]           flush_pc,
  input  logic                  excp_req,
  input  logic [31:0]           excp_vector,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  new_pc_valid,
  output logic [31:0]           new_pc,
  output logic                  hold_busy,
  output logic                  stall_timeout
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e     state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] wdog_cnt_q, wdog_cnt_d;
  logic       timeout_q, timeout_d;

  logic                  any_req;
  int unsigned           max_stage;
  logic [NUM_STAGES-1:0] merge_stall, merge_flush;
  logic                  req_stall;

  // Deepest requested stall stage wins; everything up to it holds, the next stage gets a bubble.
  always_comb begin
    any_req     = 1'b0;
    max_stage   = 0;
    merge_stall = '0;
    merge_flush = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (stallreq[i]) begin
        any_req = 1'b1;
        if (32'(REQ_STAGE[3*i +: 3]) > max_stage) max_stage = 32'(REQ_STAGE[3*i +: 3]);
      end
    end
    if (any_req) begin
      for (int unsigned j = 0; j < NUM_STAGES; j++) begin
        merge_stall[j] = (j <= max_stage);
        merge_flush[j] = (j == max_stage + 1);
      end
    end
  end

  // Only stalls that actually originate from stallreq feed the watchdog.
  assign req_stall = any_req && !excp_req && !flush_req;

  always_comb begin
    stall         = merge_stall;
    flush         = merge_flush;
    new_pc_valid  = 1'b0;
    new_pc        = 32'h0;
    hold_busy     = (state_q == StHold);
    stall_timeout = timeout_q;
    if (state_q == StHold) begin
      stall[0] = 1'b1;
      flush[1] = 1'b1;
    end
    if (excp_req) begin
      stall        = '0;
      flush        = '0;
      for (int unsigned j = 1; j < NUM_STAGES - 1; j++) flush[j] = 1'b1;
      new_pc_valid = 1'b1;
      new_pc       = excp_vector;
    end else if (flush_req) begin
      // Flushed stages and the PC are released; deeper stalled stages stay held.
      for (int unsigned j = 0; j <= BR_FLUSH; j++) begin
        stall[j] = 1'b0;
        if (j != 0) flush[j] = 1'b1;
      end
      new_pc_valid = 1'b1;
      new_pc       = flush_pc;
    end
    // Outputs are combinational from inputs, so force them quiet while reset is held.
    if (rst) begin
      stall         = '0;
      flush         = '0;
      new_pc_valid  = 1'b0;
      new_pc        = 32'h0;
      hold_busy     = 1'b0;
      stall_timeout = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (excp_req && HOLD_CYC > 0) begin
          state_d    = StHold;
          hold_cnt_d = 8'(HOLD_CYC - 1);
        end
      end
      StHold: begin
        if (excp_req) begin
          hold_cnt_d = 8'(HOLD_CYC - 1);
        end else if (hold_cnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wdog_cnt_d = 8'd0;
    if (req_stall) begin
      wdog_cnt_d = (wdog_cnt_q == 8'(WDOG_MAX)) ? wdog_cnt_q : wdog_cnt_q + 8'd1;
    end
    timeout_d = timeout_q | (wdog_cnt_d == 8'(WDOG_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      hold_cnt_q <= 8'd0;
      wdog_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      wdog_cnt_q <= wdog_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall merge, branch flush, exception hold, watchdog, async reset.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  stallreq;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic        excp_req;
  logic [31:0] excp_vector;
  logic [5:0]  stall;
  logic [5:0]  flush;
  logic        new_pc_valid;
  logic [31:0] new_pc;
  logic        hold_busy;
  logic        stall_timeout;

  int n_chk  = 0;
  int n_pass = 0;

  // Observed bundle: {stall, flush, new_pc_valid, new_pc, hold_busy, stall_timeout}
  logic [46:0] obs;
  assign obs = {stall, flush, new_pc_valid, new_pc, hold_busy, stall_timeout};

  // Source 0/1 map to stage 3, sources 2/3 to stage 2.
  pipe_ctrl #(
    .NUM_STAGES (6),
    .NUM_REQ    (4),
    .REQ_STAGE  ({3'd2, 3'd2, 3'd3, 3'd3}),
    .BR_FLUSH   (1),
    .HOLD_CYC   (2),
    .WDOG_MAX   (255)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq      (stallreq),
    .flush_req     (flush_req),
    .flush_pc      (flush_pc),
    .excp_req      (excp_req),
    .excp_vector   (excp_vector),
    .stall         (stall),
    .flush         (flush),
    .new_pc_valid  (new_pc_valid),
    .new_pc        (new_pc),
    .hold_busy     (hold_busy),
    .stall_timeout (stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    stallreq    = 4'h0;
    flush_req   = 1'b0;
    flush_pc    = 32'h0;
    excp_req    = 1'b0;
    excp_vector = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [46:0] exp;
    rst = 1'b1;
    idle_inputs();
    #12;
    exp = '0;
    n_chk++;
    if (obs !== exp) $display("FAIL reset: got %h want %h", obs, exp); else n_pass++;
    rst = 1'b0;
    next_cycle();
    n_chk++;
    if (obs !== exp) $display("FAIL reset_release: got %h want %h", obs, exp); else n_pass++;
  endtask

  task automatic test_stall_merge();
    logic [46:0] exp;
    next_cycle();
    stallreq = 4'b0001;
    #1;
    exp = {6'b001111, 6'b010000, 1'b0, 32'h0, 1'b0, 1'b0};
    n_chk++;
    if (obs !== exp) $display("FAIL merge_s3: got %h want %h", obs, exp); else n_pass++;
    stallreq = 4'b0100;
    #1;
    exp = {6'b000111, 6'b001000, 1'b0, 32'h0, 1'b0, 1'b0};
    n_chk++;
    if (obs !== exp) $display("FAIL merge_s2: got %h want %h", obs, exp); else n_pass++;
    stallreq = 4'b0110;
    #1;
    exp = {6'b001111, 6'b010000, 1'b0, 32'h0, 1'b0, 1'b0};
    n_chk++;
    if (obs !== exp) $display("FAIL merge_max: got %h want %h", obs, exp); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_branch_flush();
    logic [46:0] exp;
    next_cycle();
    flush_req = 1'b1;
    flush_pc  = 32'h0000_0040;
    #1;
    exp = {6'b000000, 6'b000010, 1'b1, 32'h0000_0040, 1'b0, 1'b0};
    n_chk++;
    if (obs !== exp) $display("FAIL br_flush: got %h want %h", obs, exp); else n_pass++;
    next_cycle();
    idle_inputs();
    #1;
    exp = '0;
    n_chk++;
    if (obs !== exp) $display("FAIL br_after: got %h want %h", obs, exp); else n_pass++;
    // Redirect beats stall on the PC only; stages 2..3 stay held.
    next_cycle();
    stallreq  = 4'b0001;
    flush_req = 1'b1;
    flush_pc  = 32'h0000_1234;
    #1;
    exp = {6'b001100, 6'b010010, 1'b1, 32'h0000_1234, 1'b0, 1'b0};
    n_chk++;
    if (obs !== exp) $display("FAIL br_with_stall: got %h want %h", obs, exp); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_exception_hold();
    logic [46:0] exp;
    next_cycle();
    excp_req    = 1'b1;
    excp_vector = 32'h0000_0180;
    flush_req   = 1'b1;
    flush_pc    = 32'h0000_0040;
    stallreq    = 4'hF;
    #1;
    exp = {6'b000000, 6'b011110, 1'b1, 32'h0000_0180, 1'b0, 1'b0};
    n_chk++;
    if (obs !== exp) $display("FAIL excp_prio: got %h want %h", obs, exp); else n_pass++;
    next_cycle();
    idle_inputs();
    #1;
    exp = {6'b000001, 6'b000010, 1'b0, 32'h0, 1'b1, 1'b0};
    for (int c = 1; c <= 2; c++) begin
      n_chk++;
      if (obs !== exp) $display("FAIL hold_cyc%0d: got %h want %h", c, obs, exp); else n_pass++;
      next_cycle();
    end
    exp = '0;
    n_chk++;
    if (obs !== exp) $display("FAIL hold_end: got %h want %h", obs, exp); else n_pass++;
  endtask

  task automatic test_hold_restart();
    logic [46:0] exp;
    next_cycle();
    excp_req    = 1'b1;
    excp_vector = 32'h0000_0100;
    next_cycle();
    idle_inputs();
    next_cycle();
    // Second HOLD cycle: a new exception redirects and restarts the hold.
    excp_req    = 1'b1;
    excp_vector = 32'h0000_0200;
    #1;
    exp = {6'b000000, 6'b011110, 1'b1, 32'h0000_0200, 1'b1, 1'b0};
    n_chk++;
    if (obs !== exp) $display("FAIL restart_redirect: got %h want %h", obs, exp); else n_pass++;
    next_cycle();
    idle_inputs();
    #1;
    exp = {6'b000001, 6'b000010, 1'b0, 32'h0, 1'b1, 1'b0};
    for (int c = 1; c <= 2; c++) begin
      n_chk++;
      if (obs !== exp) $display("FAIL restart_hold%0d: got %h want %h", c, obs, exp); else n_pass++;
      next_cycle();
    end
    exp = '0;
    n_chk++;
    if (obs !== exp) $display("FAIL restart_end: got %h want %h", obs, exp); else n_pass++;
  endtask

  task automatic test_watchdog();
    logic [46:0] exp;
    next_cycle();
    stallreq = 4'b0001;
    repeat (254) @(posedge clk);
    #1;
    exp = {6'b001111, 6'b010000, 1'b0, 32'h0, 1'b0, 1'b0};
    n_chk++;
    if (obs !== exp) $display("FAIL wdog_254: got %h want %h", obs, exp); else n_pass++;
    next_cycle();
    exp = {6'b001111, 6'b010000, 1'b0, 32'h0, 1'b0, 1'b1};
    n_chk++;
    if (obs !== exp) $display("FAIL wdog_255: got %h want %h", obs, exp); else n_pass++;
    idle_inputs();
    next_cycle();
    next_cycle();
    exp = {6'b000000, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b1};
    n_chk++;
    if (obs !== exp) $display("FAIL wdog_sticky: got %h want %h", obs, exp); else n_pass++;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    exp = '0;
    n_chk++;
    if (obs !== exp) $display("FAIL wdog_clear: got %h want %h", obs, exp); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [46:0] exp;
    next_cycle();
    excp_req    = 1'b1;
    excp_vector = 32'h0000_0300;
    next_cycle();
    idle_inputs();
    stallreq = 4'b0100;
    #1;
    exp = {6'b000111, 6'b001010, 1'b0, 32'h0, 1'b1, 1'b0};
    n_chk++;
    if (obs !== exp) $display("FAIL hold_or_merge: got %h want %h", obs, exp); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    exp = '0;
    n_chk++;
    if (obs !== exp) $display("FAIL async_rst: got %h want %h", obs, exp); else n_pass++;
    rst      = 1'b0;
    stallreq = 4'h0;
    #1;
    n_chk++;
    if (obs !== exp) $display("FAIL rst_idle: got %h want %h", obs, exp); else n_pass++;
    next_cycle();
    n_chk++;
    if (obs !== exp) $display("FAIL rst_idle_edge: got %h want %h", obs, exp); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stall_merge();
    test_branch_flush();
    test_exception_hold();
    test_hold_restart();
    test_watchdog();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
